// File: rtl/sm4_round_key_generator_if.sv
// Round-key interface: master-key load, stream request and round-key stream.
// Latency: none, wires only.
// Backpressure: key_valid/key_ready for key load, rk_valid/rk_ready for key stream.
interface sm4_round_key_generator_if #(
  parameter int IDX_W = 5
);
  logic [127:0]     key_in;
  logic             key_valid;
  logic             key_ready;
  logic             start;
  logic             decrypt;
  logic [31:0]      rk_out;
  logic [IDX_W-1:0] rk_index;
  logic             rk_valid;
  logic             rk_ready;
  logic             rk_last;
  logic             keys_loaded;
  logic             busy;

  // Controller / key source side
  modport master (
    output key_in, key_valid, start, decrypt, rk_ready,
    input  key_ready, rk_out, rk_index, rk_valid, rk_last, keys_loaded, busy
  );

  // Key generator side
  modport slave (
    input  key_in, key_valid, start, decrypt, rk_ready,
    output key_ready, rk_out, rk_index, rk_valid, rk_last, keys_loaded, busy
  );
endinterface

// File: rtl/sm4_round_key_generator.sv
// SM4 key schedule: expands a master key into a 32-entry round-key store, then streams it.
// Latency: keys_loaded 32 cycles after key handshake; first key 1 cycle after start, then 1/cycle.
// Backpressure: rk_ready low freezes rk_out/rk_index/rk_last; key_ready low in EXPAND/STREAM.
module sm4_round_key_generator #(
  parameter int NUM_ROUNDS = 32,
  parameter int IDX_W      = 5
) (
  input logic                      clk,
  input logic                      rst_n,
  sm4_round_key_generator_if.slave bus
);

  generate
    if (NUM_ROUNDS != 32 || IDX_W != 5) begin : g_bad_params
      $error("sm4_round_key_generator supports only NUM_ROUNDS=32, IDX_W=5");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_READY, S_STREAM} state_t;

  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  // Same S-box table as the round datapath
  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  state_t           r_state;
  logic [31:0]      r_k0, r_k1, r_k2, r_k3;
  logic [IDX_W-1:0] r_cnt;
  logic             r_dec;
  logic [31:0]      r_store [NUM_ROUNDS];
  logic [31:0]      r_rk_out;
  logic [IDX_W-1:0] r_rk_index;
  logic             r_rk_valid;
  logic             r_rk_last;
  logic             r_keys_loaded;
  logic             r_busy;
  logic             r_key_ready;

  logic [7:0]       w_ck_base;
  logic [31:0]      w_ck;
  logic [31:0]      w_x;
  logic [31:0]      w_tau;
  logic [31:0]      w_rk;
  logic             w_key_fire;
  logic             w_rk_fire;
  logic             w_cnt_last;
  logic [IDX_W-1:0] w_start_idx;
  logic [IDX_W-1:0] w_next_idx;

  // CK_i byte j = (4i+j)*7 mod 256, so the MSB byte is 28*i and the rest step by 7
  assign w_ck_base = 8'(r_cnt) * 8'd28;
  assign w_ck      = {w_ck_base, w_ck_base + 8'd7, w_ck_base + 8'd14, w_ck_base + 8'd21};

  // Key-schedule round: rk_i = K_i ^ L'(tau(K_{i+1} ^ K_{i+2} ^ K_{i+3} ^ CK_i))
  assign w_x   = r_k1 ^ r_k2 ^ r_k3 ^ w_ck;
  assign w_tau = {sbox(w_x[31:24]), sbox(w_x[23:16]), sbox(w_x[15:8]), sbox(w_x[7:0])};
  assign w_rk  = r_k0 ^ w_tau ^ {w_tau[18:0], w_tau[31:19]} ^ {w_tau[8:0], w_tau[31:9]};

  assign w_key_fire  = bus.key_valid & r_key_ready;
  assign w_rk_fire   = r_rk_valid & bus.rk_ready;
  assign w_cnt_last  = (r_cnt == IDX_W'(NUM_ROUNDS - 1));
  assign w_start_idx = bus.decrypt ? IDX_W'(NUM_ROUNDS - 1) : '0;
  assign w_next_idx  = r_dec ? (r_rk_index - IDX_W'(1)) : (r_rk_index + IDX_W'(1));

  // Control FSM with registered outputs; a key load wins over start in READY
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_key_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_keys_loaded <= 1'b0;
      r_rk_valid    <= 1'b0;
      r_rk_last     <= 1'b0;
      r_rk_out      <= '0;
      r_rk_index    <= '0;
      r_cnt         <= '0;
      r_dec         <= 1'b0;
      r_k0          <= '0;
      r_k1          <= '0;
      r_k2          <= '0;
      r_k3          <= '0;
    end else if (w_key_fire) begin
      r_k0          <= bus.key_in[127:96] ^ FK0;
      r_k1          <= bus.key_in[95:64]  ^ FK1;
      r_k2          <= bus.key_in[63:32]  ^ FK2;
      r_k3          <= bus.key_in[31:0]   ^ FK3;
      r_cnt         <= '0;
      r_keys_loaded <= 1'b0;
      r_busy        <= 1'b1;
      r_key_ready   <= 1'b0;
      r_state       <= S_EXPAND;
    end else begin
      case (r_state)
        S_EXPAND: begin
          r_k0 <= r_k1;
          r_k1 <= r_k2;
          r_k2 <= r_k3;
          r_k3 <= w_rk;
          if (w_cnt_last) begin
            r_keys_loaded <= 1'b1;
            r_busy        <= 1'b0;
            r_key_ready   <= 1'b1;
            r_state       <= S_READY;
          end else begin
            r_cnt <= r_cnt + IDX_W'(1);
          end
        end
        S_READY: begin
          if (bus.start) begin
            r_dec       <= bus.decrypt;
            r_rk_valid  <= 1'b1;
            r_rk_index  <= w_start_idx;
            r_rk_out    <= r_store[w_start_idx];
            r_rk_last   <= 1'b0;  // first key of a 32-key stream is never the last
            r_busy      <= 1'b1;
            r_key_ready <= 1'b0;
            r_state     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_rk_fire) begin
            if (r_rk_last) begin
              r_rk_valid  <= 1'b0;
              r_rk_last   <= 1'b0;
              r_busy      <= 1'b0;
              r_key_ready <= 1'b1;
              r_state     <= S_READY;
            end else begin
              r_rk_index <= w_next_idx;
              r_rk_out   <= r_store[w_next_idx];
              r_rk_last  <= r_dec ? (w_next_idx == '0) : (w_next_idx == IDX_W'(NUM_ROUNDS - 1));
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Key store: EXPAND writes one round key per cycle at the counter position
  always_ff @(posedge clk) begin
    if (rst_n && r_state == S_EXPAND) begin
      r_store[r_cnt] <= w_rk;
    end
  end

  assign bus.key_ready   = r_key_ready;
  assign bus.rk_out      = r_rk_out;
  assign bus.rk_index    = r_rk_index;
  assign bus.rk_valid    = r_rk_valid;
  assign bus.rk_last     = r_rk_last;
  assign bus.keys_loaded = r_keys_loaded;
  assign bus.busy        = r_busy;

endmodule
